// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the four hex digits shown on a multiplexed
// active-low 7-segment display by watching its segment and anode lines.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   seg[6:0]     segment lines, active-low, seg[0]=a .. seg[6]=g
//   an[3:0]      digit enables, active-low, an[i]=0 selects digit i
//   err_clr      one-cycle pulse clearing a sticky err
//   value[15:0]  decoded nibbles, value[4i+3:4i] is digit i
//   digit_valid  bit i set when digit i's last capture was a legal code
//   frame_done   one-cycle pulse once all four digits have been captured
//   err          set on capture of an unknown segment pattern
// Macro SEG_SCAN_STICKY_ERR_EN: when defined err holds until err_clr or
// reset; when undefined err pulses per bad capture and err_clr is ignored.

module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        err_clr,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        err
);

    localparam logic [7:0] LIMIT  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 2);

    logic [6:0] seg_q;
    logic [3:0] an_q;
    logic [6:0] seg_p;
    logic [3:0] an_p;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [3:0] mask;
    logic       sel;
    logic       same;
    logic       capture;
    logic [3:0] cap_mask;
    logic       hit;
    logic [3:0] nib;
    logic       err_set;
    logic       frame_full;

    // Exactly one anode low means a single digit is being driven.
    assign sel  = $onehot(~an_q);
    assign same = ({an_q, seg_q} == {an_p, seg_p});

    // The counter saturates above CAP_AT, so a held pattern fires once.
    assign capture  = sel && same && (cnt == CAP_AT);
    assign cap_mask = capture ? ~an_q : 4'h0;
    assign err_set  = capture && !hit;
    assign frame_full = (mask == 4'hF);

    always_comb begin
        cnt_next = 8'd0;
        if (sel && same) begin
            cnt_next = (cnt == LIMIT) ? cnt : cnt + 8'd1;
        end
    end

    always_comb begin
        hit = 1'b1;
        nib = 4'h0;
        case (seg_q)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    hit = 1'b0;
        endcase
    end

`ifndef SEG_SCAN_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= '1;
            an_q        <= '1;
            seg_p       <= '1;
            an_p        <= '1;
            cnt         <= 8'd0;
            mask        <= 4'h0;
            value       <= 16'h0000;
            digit_valid <= 4'h0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            seg_q <= seg;
            an_q  <= an;
            seg_p <= seg_q;
            an_p  <= an_q;
            cnt   <= cnt_next;
            // A full mask restarts the frame; a capture now joins the new one.
            frame_done <= frame_full;
            mask <= (frame_full ? 4'h0 : mask) | cap_mask;
            for (int i = 0; i < 4; i++) begin
                if (cap_mask[i]) begin
                    if (hit) begin
                        value[4*i +: 4] <= nib;
                    end
                    digit_valid[i] <= hit;
                end
            end
`ifdef SEG_SCAN_STICKY_ERR_EN
            err <= err_set | (err & ~err_clr);
`else
            err <= err_set;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: vector table, directed timing sequences and a
// randomized run checked against a run-length reference model.

module tb_seg_scan_decoder;

    localparam int S = 4;

    localparam logic [6:0] CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

`ifdef SEG_SCAN_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '1;
    logic [3:0]  an = '1;
    logic        err_clr = 1'b0;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int err_cnt = 0;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg(seg),
        .an(an),
        .err_clr(err_clr),
        .value(value),
        .digit_valid(digit_valid),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int lookup(logic [6:0] s);
        for (int k = 0; k < 16; k++) if (CODES[k] == s) return k;
        return -1;
    endfunction

    function automatic int dig(logic [3:0] a);
        for (int k = 0; k < 4; k++) if (!a[k]) return k;
        return 0;
    endfunction

    logic [15:0] m_value = '0;
    logic [3:0]  m_dv = '0;
    logic [3:0]  m_mask = '0;
    logic        m_fd = 1'b0;
    logic        m_err = 1'b0;
    int          run = 0;
    logic [10:0] last = '1;
    logic        pend = 1'b0;
    logic [3:0]  pend_an = '1;
    logic [6:0]  pend_seg = '1;

    // run counts consecutive identical selecting pin samples; the digit is
    // taken one edge after that run reaches exactly S.
    always @(posedge clk) begin : model
        logic fire;
        logic bad;
        int   idx;
        int   code;
        if (!rst_n) begin
            m_value = '0; m_dv = '0; m_mask = '0;
            m_fd = 1'b0; m_err = 1'b0;
            run = 0; last = '1; pend = 1'b0;
        end else begin
            fire = (m_mask == 4'hF);
            if (fire) m_mask = 4'h0;
            m_fd = fire;
            bad = 1'b0;
            if (pend) begin
                idx = dig(pend_an);
                code = lookup(pend_seg);
                m_mask[idx] = 1'b1;
                if (code >= 0) begin
                    m_value[idx*4 +: 4] = 4'(code);
                    m_dv[idx] = 1'b1;
                end else begin
                    m_dv[idx] = 1'b0;
                    bad = 1'b1;
                end
            end
            if (STICKY) m_err = bad | (m_err & ~err_clr);
            else        m_err = bad;
            if ($countones(~an) == 1)
                run = ({an, seg} == last) ? run + 1 : 1;
            else
                run = 0;
            last = {an, seg};
            pend = (run == S);
            pend_an = an;
            pend_seg = seg;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (err) err_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; an = '1; seg = '1; err_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_dv", 32'(digit_valid), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        fd_cnt = 0;
        err_cnt = 0;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] value;
        logic [3:0]  dv;
        logic        err_s;
    } vec_t;

    vec_t vt [9];

    initial begin
        vt[0] = '{4'b1110, 7'b0010010, 10, 16'h0005, 4'b0001, 1'b0};
        vt[1] = '{4'b1101, 7'b1111001,  8, 16'h0015, 4'b0011, 1'b0};
        vt[2] = '{4'b1011, 7'b0111111,  8, 16'h0015, 4'b0011, 1'b1};
        vt[3] = '{4'b0111, 7'b0001000,  8, 16'hA015, 4'b1011, 1'b1};
        vt[4] = '{4'b1011, 7'b1000110,  8, 16'hAC15, 4'b1111, 1'b1};
        vt[5] = '{4'b1110, 7'b1111111,  8, 16'hAC15, 4'b1110, 1'b1};
        vt[6] = '{4'b1100, 7'b0000000, 20, 16'hAC15, 4'b1110, 1'b1};
        vt[7] = '{4'b0000, 7'b0000000,  8, 16'hAC15, 4'b1110, 1'b1};
        vt[8] = '{4'b1110, 7'b0001110,  8, 16'hAC1F, 4'b1111, 1'b1};

        // table-driven run from reset
        do_reset();
        for (int i = 0; i < 9; i++) begin
            an = vt[i].an;
            seg = vt[i].seg;
            tick(vt[i].hold);
            chk($sformatf("vec%0d_value", i), 32'(value), 32'(vt[i].value));
            chk($sformatf("vec%0d_dv", i), 32'(digit_valid), 32'(vt[i].dv));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err_s & STICKY));
        end

        // exact capture latency
        do_reset();
        an = 4'b1110; seg = 7'b0010010;
        for (int e = 1; e <= S + 1; e++) begin
            tick(1);
            chk($sformatf("lat_e%0d_value", e), 32'(value),
                (e == S + 1) ? 32'h5 : 32'h0);
            chk($sformatf("lat_e%0d_dv", e), 32'(digit_valid),
                (e == S + 1) ? 32'h1 : 32'h0);
        end
        tick(4);
        chk("lat_hold_value", 32'(value), 32'h5);
        chk("lat_err_cnt", 32'(err_cnt), 32'h0);

        // full scan gives one frame
        do_reset();
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d);
            seg = CODES[d + 1];
            tick(8);
        end
        an = '1; seg = '1;
        tick(3);
        chk("scan_value", 32'(value), 32'h4321);
        chk("scan_dv", 32'(digit_valid), 32'hF);
        chk("scan_fd_cnt", 32'(fd_cnt), 32'h1);

        // segment chatter never settles
        do_reset();
        an = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            seg = k[0] ? CODES[3] : CODES[2];
            tick(2);
        end
        chk("chat_value", 32'(value), 32'h0);
        chk("chat_dv", 32'(digit_valid), 32'h0);
        chk("chat_fd_cnt", 32'(fd_cnt), 32'h0);

        // illegal pattern
        do_reset();
        an = 4'b1011; seg = 7'b0111111;
        tick(8);
        chk("bad_dv", 32'(digit_valid), 32'h0);
        chk("bad_value", 32'(value), 32'h0);
        chk("bad_err", 32'(err), STICKY ? 32'h1 : 32'h0);
        chk("bad_err_cnt", 32'(err_cnt), STICKY ? 32'h4 : 32'h1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("bad_err_clr", 32'(err), 32'h0);

        // two anodes low, then reset in mid count
        do_reset();
        an = 4'b1100; seg = CODES[8];
        tick(20);
        chk("multi_value", 32'(value), 32'h0);
        chk("multi_dv", 32'(digit_valid), 32'h0);
        an = 4'b1110; seg = 7'b0010010;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mid_rst_value", 32'(value), 32'h0);
        chk("mid_rst_dv", 32'(digit_valid), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        tick(S);
        chk("mid_rst_pre", 32'(value), 32'h0);
        tick(1);
        chk("mid_rst_post", 32'(value), 32'h5);

        // err_clr colliding with an error-setting capture
        do_reset();
        an = 4'b1110; seg = 7'b0111111;
        tick(S);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("clr_race_err", 32'(err), 32'h1);
        tick(1);
        chk("clr_race_after", 32'(err), STICKY ? 32'h1 : 32'h0);

        // randomized run against the model
        do_reset();
        for (int t = 0; t < 300; t++) begin
            int h;
            if ($urandom_range(0, 9) == 0) an = 4'($urandom);
            else an = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) seg = 7'($urandom);
            else seg = CODES[$urandom_range(0, 15)];
            h = $urandom_range(1, 8);
            for (int c = 0; c < h; c++) begin
                err_clr = ($urandom_range(0, 3) == 0);
                rst_n = ($urandom_range(0, 199) != 0);
                @(negedge clk);
                chk("rnd_value", 32'(value), 32'(m_value));
                chk("rnd_dv", 32'(digit_valid), 32'(m_dv));
                chk("rnd_fd", 32'(frame_done), 32'(m_fd));
                chk("rnd_err", 32'(err), 32'(m_err));
            end
        end
        rst_n = 1'b1;
        err_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
